axi4_burst_slave_mem: RTL and testbench

- AXI4 (full) slave endpoint backed by an internal 32-bit word memory.
- Responds to the burst master agent in the block-design test harness: accepts write bursts, stores data honouring WSTRB, and returns read bursts.
- Independent write and read channel state machines; one outstanding transaction per direction; one beat per cycle on W and R.

---
 rtl/axi4_burst_slave_mem.sv | 275 +++++++++++++++++++++++++++
 tb/tb_axi4_burst_slave_mem.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_slave_mem.sv
// axi4_burst_slave_mem
//   AXI4 slave endpoint backed by a 2**C_MEM_DEPTH_LOG2 x 32-bit word memory.
//   Write and read channels each run their own FSM with one outstanding burst
//   per direction and one beat per cycle. Supports FIXED/INCR/WRAP bursts of
//   32-bit beats. An unsupported size or burst type marks the burst as an
//   error: writes are dropped, reads return zero, and the response is SLVERR.
//   An illegal WRAP length is carried out as INCR and answered with SLVERR.
//
// Ports
//   ACLK, ARESET                     clock, async active-high reset
//   AW*  (ID/ADDR/LEN/SIZE/BURST)    write command, AWVALID/AWREADY
//   W*   (DATA/STRB/LAST)            write data, WVALID/WREADY
//   B*   (ID/RESP)                   write response, BVALID/BREADY
//   AR*  (ID/ADDR/LEN/SIZE/BURST)    read command, ARVALID/ARREADY
//   R*   (ID/DATA/RESP/LAST)         read data, RVALID/RREADY
//
// Write FSM
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write command
//   W_DATA | WREADY high, accepting beats until WLAST
//   W_RESP | BVALID high, waiting for BREADY
//
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for a read command
//   R_DATA | RVALID high, one beat per RREADY, leaves on the RLAST beat

module axi4_burst_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 10,
    parameter int C_MEM_DEPTH_LOG2   = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic [2:0]                    AWSIZE,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [31:0]                   WDATA,
    input  logic [3:0]                    WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   BID,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]   ARID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [2:0]                    ARSIZE,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]   RID,
    output logic [31:0]                   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int         DL          = C_MEM_DEPTH_LOG2;
    localparam int         DEPTH       = 1 << DL;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef logic [DL-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic cmd_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || (burst == 2'b11);
    endfunction

    function automatic logic wrap_bad(input logic [1:0] burst, input logic [7:0] len);
        return (burst == 2'b10) && !wrap_len_ok(len);
    endfunction

    // For a legal WRAP the low log2(LEN+1) index bits count and the rest stay
    // put, which keeps the burst inside its (LEN+1)-word aligned window.
    function automatic idx_t next_idx(input idx_t idx, input logic [7:0] len,
                                      input logic [1:0] burst);
        idx_t mask;
        idx_t inc;
        mask = idx_t'(len[3:0]);
        inc  = idx + idx_t'(1);
        case (burst)
            2'b00:   return idx;
            2'b10:   return wrap_len_ok(len) ? ((idx & ~mask) | (inc & mask)) : inc;
            default: return inc;
        endcase
    endfunction

    logic [31:0] mem [DEPTH];

    // Only the word-index bits are decoded; the rest alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{AWADDR, ARADDR};

    // ------------------------------------------------------------------ write
    w_state_t                    w_state, w_state_nx;
    logic [C_S_AXI_ID_WIDTH-1:0] w_id;
    idx_t                        w_idx;
    logic [7:0]                  w_len;
    logic [1:0]                  w_burst;
    logic                        w_cmd_err;
    logic                        w_wrap_err;
    logic                        w_len_err;
    logic [8:0]                  w_beat;
    logic                        awready_st, wready_st, bvalid_st;
    logic                        aw_hs, w_hs, w_in_range, w_beat_err, mem_we;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) w_state <= W_IDLE;
        else        w_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = w_state;
        awready_st = 1'b0;
        wready_st  = 1'b0;
        bvalid_st  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready_st = 1'b1;
                if (AWVALID) w_state_nx = W_DATA;
            end
            W_DATA: begin
                wready_st = 1'b1;
                if (WVALID && WLAST) w_state_nx = W_RESP;
            end
            W_RESP: begin
                bvalid_st = 1'b1;
                if (BREADY) w_state_nx = W_IDLE;
            end
            default: w_state_nx = W_IDLE;
        endcase
    end

    // Ready is masked by reset so nothing is offered while reset is held.
    assign AWREADY = awready_st & ~ARESET;
    assign WREADY  = wready_st;
    assign BVALID  = bvalid_st;

    assign aw_hs      = AWVALID & AWREADY;
    assign w_hs       = WVALID & wready_st;
    assign w_in_range = (w_beat <= {1'b0, w_len});
    // A beat at or past LEN without WLAST means the burst will overrun.
    assign w_beat_err = WLAST ? (w_beat != {1'b0, w_len}) : (w_beat >= {1'b0, w_len});
    assign mem_we     = w_hs & w_in_range & ~w_cmd_err;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_id       <= '0;
            w_idx      <= '0;
            w_len      <= '0;
            w_burst    <= '0;
            w_cmd_err  <= 1'b0;
            w_wrap_err <= 1'b0;
            w_len_err  <= 1'b0;
            w_beat     <= '0;
            BID        <= '0;
            BRESP      <= RESP_OKAY;
        end else begin
            if (aw_hs) begin
                w_id       <= AWID;
                w_idx      <= AWADDR[DL+1:2];
                w_len      <= AWLEN;
                w_burst    <= AWBURST;
                w_cmd_err  <= cmd_bad(AWSIZE, AWBURST);
                w_wrap_err <= wrap_bad(AWBURST, AWLEN);
                w_len_err  <= 1'b0;
                w_beat     <= '0;
            end
            if (w_hs) begin
                w_idx <= next_idx(w_idx, w_len, w_burst);
                if (!w_beat[8]) w_beat <= w_beat + 9'd1;
                if (w_beat_err) w_len_err <= 1'b1;
                if (WLAST) begin
                    BID   <= w_id;
                    BRESP <= (w_cmd_err | w_wrap_err | w_len_err | w_beat_err)
                             ? RESP_SLVERR : RESP_OKAY;
                end
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (WSTRB[i]) mem[w_idx][8*i +: 8] <= WDATA[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------- read
    r_state_t   r_state, r_state_nx;
    idx_t       r_idx, ar_idx, r_idx_nx;
    logic [7:0] r_len;
    logic [7:0] r_beat;
    logic [1:0] r_burst;
    logic       r_cmd_err;
    logic       r_resp_err;
    logic       arready_st, rvalid_st;
    logic       ar_hs, r_more;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_state <= R_IDLE;
        else        r_state <= r_state_nx;
    end

    always_comb begin
        r_state_nx = r_state;
        arready_st = 1'b0;
        rvalid_st  = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready_st = 1'b1;
                if (ARVALID) r_state_nx = R_DATA;
            end
            R_DATA: begin
                rvalid_st = 1'b1;
                if (RREADY && (r_beat == r_len)) r_state_nx = R_IDLE;
            end
            default: r_state_nx = R_IDLE;
        endcase
    end

    assign ARREADY = arready_st & ~ARESET;
    assign RVALID  = rvalid_st;
    assign RLAST   = rvalid_st & (r_beat == r_len);
    assign RRESP   = (rvalid_st && r_resp_err) ? RESP_SLVERR : RESP_OKAY;

    assign ar_hs    = ARVALID & ARREADY;
    assign r_more   = rvalid_st & RREADY & (r_beat != r_len);
    assign ar_idx   = ARADDR[DL+1:2];
    assign r_idx_nx = next_idx(r_idx, r_len, r_burst);

    // RDATA is registered from the array, so a word written on the same edge
    // is seen as its old contents on this beat and as new data afterwards.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            RID        <= '0;
            RDATA      <= '0;
            r_idx      <= '0;
            r_len      <= '0;
            r_beat     <= '0;
            r_burst    <= '0;
            r_cmd_err  <= 1'b0;
            r_resp_err <= 1'b0;
        end else if (ar_hs) begin
            RID        <= ARID;
            r_idx      <= ar_idx;
            r_len      <= ARLEN;
            r_beat     <= '0;
            r_burst    <= ARBURST;
            r_cmd_err  <= cmd_bad(ARSIZE, ARBURST);
            r_resp_err <= cmd_bad(ARSIZE, ARBURST) | wrap_bad(ARBURST, ARLEN);
            RDATA      <= cmd_bad(ARSIZE, ARBURST) ? '0 : mem[ar_idx];
        end else if (r_more) begin
            r_idx  <= r_idx_nx;
            r_beat <= r_beat + 8'd1;
            RDATA  <= r_cmd_err ? '0 : mem[r_idx_nx];
        end
    end

endmodule

// File: tb/tb_axi4_burst_slave_mem.sv
module tb_axi4_burst_slave_mem;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [0:0]  AWID, BID, ARID, RID;
    logic [9:0]  AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [3:0]  WSTRB;

    always #5 ACLK = ~ACLK;

    axi4_burst_slave_mem dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] model [256];

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [0:0] id; } rexp_t;
    rexp_t exp_q[$];

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [0:0]  id;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[8];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Byte-address model of burst address progression.
    function automatic logic [9:0] nxt_addr(input logic [9:0] a, input logic [7:0] len,
                                            input logic [1:0] burst);
        int sz, base, n;
        if (burst == FIXED) return a;
        if (burst == WRAP && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            sz   = (int'(len) + 1) * 4;
            base = (int'(a) / sz) * sz;
            n    = int'(a) + 4;
            if (n >= base + sz) n = base;
            return 10'(n);
        end
        return a + 10'd4;
    endfunction

    task automatic wr_burst(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input int nbeats, input logic [3:0] strb,
                            input logic [31:0] d0, input logic [0:0] id, input logic [1:0] exp_resp);
        logic [9:0] a;
        logic       cmd_err;
        int         n;
        cmd_err = (size != 3'd2) || (burst == 2'b11);
        @(negedge ACLK);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("awready", 32'(AWREADY), 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        a = addr;
        for (int b = 0; b < nbeats; b++) begin
            WDATA = d0 + 32'(b); WSTRB = strb; WLAST = (b == nbeats - 1); WVALID = 1'b1;
            n = 0;
            while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
            chk("wready", 32'(WREADY), 32'd1);
            if (!cmd_err && b <= int'(len))
                for (int k = 0; k < 4; k++)
                    if (strb[k]) model[a[9:2]][8*k +: 8] = WDATA[8*k +: 8];
            a = nxt_addr(a, len, burst);
            @(negedge ACLK);
        end
        WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("bvalid", 32'(BVALID), 32'd1);
        chk("bresp", 32'(BRESP), 32'(exp_resp));
        chk("bid", 32'(BID), 32'(id));
        @(negedge ACLK);
        BREADY = 1'b0;
        chk("bvalid_drop", 32'(BVALID), 32'd0);
    endtask

    task automatic rd_burst(input logic [9:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [2:0] size, input logic [0:0] id, input int stall,
                            output logic [31:0] last_data);
        logic [9:0] a;
        logic       cmd_err, wrap_bad;
        int         n, beats, cyc;
        rexp_t      e;
        cmd_err  = (size != 3'd2) || (burst == 2'b11);
        wrap_bad = (burst == WRAP) && !(len == 1 || len == 3 || len == 7 || len == 15);
        a = addr;
        for (int b = 0; b <= int'(len); b++) begin
            e.data = cmd_err ? 32'd0 : model[a[9:2]];
            e.resp = (cmd_err || wrap_bad) ? SLVERR : OKAY;
            e.last = (b == int'(len));
            e.id   = id;
            exp_q.push_back(e);
            a = nxt_addr(a, len, burst);
        end
        last_data = '0;
        @(negedge ACLK);
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("arready", 32'(ARREADY), 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0;
        beats = 0; cyc = 0;
        while (beats <= int'(len) && cyc < 300) begin
            RREADY = (stall == 0) ? 1'b1 : (cyc % 3 == 0);
            if (RVALID) begin
                if (exp_q.size() == 0) begin
                    chk("r_extra_beat", 32'(RVALID), 32'd0);
                end else begin
                    e = exp_q[0];
                    chk("rdata", RDATA, e.data);
                    chk("rresp", 32'(RRESP), 32'(e.resp));
                    chk("rlast", 32'(RLAST), 32'(e.last));
                    chk("rid", 32'(RID), 32'(e.id));
                    if (RREADY) begin
                        last_data = RDATA;
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
            end
            @(negedge ACLK);
            cyc++;
        end
        RREADY = 1'b0;
        chk("r_beats", 32'(beats), 32'(len) + 32'd1);
        chk("rvalid_end", 32'(RVALID), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ld, ld2;
        logic [9:0]  a;

        tbl[0] = '{10'h000, 32'h0000_0001, 4'hF,    1'b0, 32'h0000_0001};
        tbl[1] = '{10'h004, 32'h0000_0002, 4'hF,    1'b1, 32'h0000_0002};
        tbl[2] = '{10'h008, 32'h0000_0003, 4'hF,    1'b0, 32'h0000_0003};
        tbl[3] = '{10'h00C, 32'h0000_0004, 4'hF,    1'b1, 32'h0000_0004};
        tbl[4] = '{10'h020, 32'h1122_3344, 4'hF,    1'b0, 32'h1122_3344};
        tbl[5] = '{10'h020, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'h11BB_33DD};
        tbl[6] = '{10'h024, 32'h1122_3344, 4'hF,    1'b0, 32'h1122_3344};
        tbl[7] = '{10'h024, 32'hAABB_CCDD, 4'b0100, 1'b1, 32'h11BB_3344};

        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = INCR; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = INCR; ARVALID = 1'b0;
        RREADY = 1'b0;

        repeat (3) @(negedge ACLK);
        chk("rst_awready_held", 32'(AWREADY), 32'd0);
        chk("rst_arready_held", 32'(ARREADY), 32'd0);
        ARESET = 1'b0;
        #1;
        chk("rst_awready", 32'(AWREADY), 32'd1);
        chk("rst_arready", 32'(ARREADY), 32'd1);
        chk("rst_wready",  32'(WREADY),  32'd0);
        chk("rst_bvalid",  32'(BVALID),  32'd0);
        chk("rst_rvalid",  32'(RVALID),  32'd0);
        chk("rst_rlast",   32'(RLAST),   32'd0);
        chk("rst_bresp",   32'(BRESP),   32'd0);
        chk("rst_rresp",   32'(RRESP),   32'd0);
        chk("rst_rdata",   RDATA,        32'd0);
        chk("rst_bid",     32'(BID),     32'd0);
        chk("rst_rid",     32'(RID),     32'd0);

        // 8-beat INCR write then read back
        wr_burst(10'h000, 8'd7, INCR, 3'd2, 8, 4'hF, 32'd1, 1'b0, OKAY);
        rd_burst(10'h000, 8'd7, INCR, 3'd2, 1'b0, 0, ld);
        chk("incr8_last", ld, 32'd8);

        // single-beat write/read vectors, including byte strobes
        for (int i = 0; i < 8; i++) begin
            wr_burst(tbl[i].addr, 8'd0, INCR, 3'd2, 1, tbl[i].strb, tbl[i].wdata, tbl[i].id, OKAY);
            rd_burst(tbl[i].addr, 8'd0, INCR, 3'd2, tbl[i].id, 0, ld);
            chk("vec_rdata", ld, tbl[i].exp);
        end

        // WRAP write at 0x18, then INCR and WRAP reads of the window
        wr_burst(10'h018, 8'd3, WRAP, 3'd2, 4, 4'hF, 32'hA, 1'b0, OKAY);
        rd_burst(10'h010, 8'd3, INCR, 3'd2, 1'b0, 0, ld);
        chk("wrap_incr_last", ld, 32'hB);
        rd_burst(10'h018, 8'd3, WRAP, 3'd2, 1'b1, 0, ld);
        chk("wrap_wrap_last", ld, 32'hD);

        // unsupported size: write dropped with SLVERR, read returns zeros
        wr_burst(10'h040, 8'd0, INCR, 3'd2, 1, 4'hF, 32'h55, 1'b0, OKAY);
        wr_burst(10'h040, 8'd1, INCR, 3'd1, 2, 4'hF, 32'h99, 1'b1, SLVERR);
        rd_burst(10'h040, 8'd0, INCR, 3'd2, 1'b0, 0, ld);
        chk("size_err_unchanged", ld, 32'h55);
        rd_burst(10'h040, 8'd1, INCR, 3'd1, 1'b0, 0, ld);
        wr_burst(10'h044, 8'd0, 2'b11, 3'd2, 1, 4'hF, 32'h77, 1'b0, SLVERR);

        // illegal WRAP length runs as INCR with SLVERR
        wr_burst(10'h060, 8'd2, WRAP, 3'd2, 3, 4'hF, 32'h70, 1'b0, SLVERR);
        rd_burst(10'h060, 8'd2, INCR, 3'd2, 1'b0, 0, ld);
        chk("badwrap_last", ld, 32'h72);

        // FIXED burst: all beats land on one word
        wr_burst(10'h080, 8'd3, FIXED, 3'd2, 4, 4'hF, 32'h200, 1'b0, OKAY);
        rd_burst(10'h080, 8'd1, FIXED, 3'd2, 1'b0, 0, ld);
        chk("fixed_last", ld, 32'h203);

        // RREADY stalled 1,0,0,1,...
        rd_burst(10'h000, 8'd7, INCR, 3'd2, 1'b0, 1, ld);

        // reset in the middle of a read burst
        wr_burst(10'h100, 8'd7, INCR, 3'd2, 8, 4'hF, 32'h700, 1'b0, OKAY);
        @(negedge ACLK);
        ARID = 1'b0; ARADDR = 10'h100; ARLEN = 8'd7; ARSIZE = 3'd2; ARBURST = INCR; ARVALID = 1'b1;
        chk("rst_rd_arready", 32'(ARREADY), 32'd1);
        @(negedge ACLK);
        ARVALID = 1'b0; RREADY = 1'b1;
        for (int b = 0; b < 3; b++) begin
            a = 10'h100 + 10'(4 * b);
            chk("rst_rd_data", RDATA, model[a[9:2]]);
            @(negedge ACLK);
        end
        chk("rst_rd_beat4_valid", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        #1;
        chk("rst_mid_rvalid", 32'(RVALID), 32'd0);
        chk("rst_mid_rlast", 32'(RLAST), 32'd0);
        chk("rst_mid_rdata", RDATA, 32'd0);
        chk("rst_mid_arready", 32'(ARREADY), 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0; RREADY = 1'b0;
        #1;
        chk("rst_rel_arready", 32'(ARREADY), 32'd1);
        chk("rst_rel_awready", 32'(AWREADY), 32'd1);
        chk("rst_rel_rvalid", 32'(RVALID), 32'd0);
        rd_burst(10'h100, 8'd7, INCR, 3'd2, 1'b0, 0, ld);
        chk("mem_kept_last", ld, 32'h707);

        // early WLAST and overlong write bursts
        wr_burst(10'h0C0, 8'd3, INCR, 3'd2, 3, 4'hF, 32'h300, 1'b0, SLVERR);
        rd_burst(10'h0C0, 8'd2, INCR, 3'd2, 1'b0, 0, ld);
        chk("early_wlast_last", ld, 32'h302);
        wr_burst(10'h0D0, 8'd3, INCR, 3'd2, 4, 4'hF, 32'h400, 1'b0, OKAY);
        wr_burst(10'h0D0, 8'd1, INCR, 3'd2, 4, 4'hF, 32'h500, 1'b1, SLVERR);
        rd_burst(10'h0D0, 8'd3, INCR, 3'd2, 1'b0, 0, ld);
        chk("overlong_discard", ld, 32'h403);

        // concurrent write and read to different regions
        fork
            wr_burst(10'h200, 8'd3, INCR, 3'd2, 4, 4'hF, 32'h600, 1'b1, OKAY);
            rd_burst(10'h000, 8'd7, INCR, 3'd2, 1'b1, 0, ld);
        join
        rd_burst(10'h200, 8'd3, INCR, 3'd2, 1'b0, 0, ld2);
        chk("concurrent_wr_last", ld2, 32'h603);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
